alu_cmd_issuer: RTL

Command-side front end for the 8-bit ALU. Accepts one operation per valid/ready handshake and drives `A`, `B` and `opcode` into the ALU, holding them stable for the ALU's registered latency. It then captures `ALU_Out`, optionally writes it to an 8-bit accumulator, and presents the result on a valid/ready output. It sits between the instruction source and the ALU, as the initiator for which the ALU is the responder.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_cmd_issuer.sv | 95 +++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes and issuer FSM states for the 8-bit ALU
package alu_pkg;

  localparam int ALU_W = 8;
  localparam int OP_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0010;
  localparam logic [OP_W-1:0] OP_DIV = 4'b0011;
  localparam logic [OP_W-1:0] OP_SHL = 4'b0100;
  localparam logic [OP_W-1:0] OP_SHR = 4'b0101;
  localparam logic [OP_W-1:0] OP_AND = 4'b1000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b1001;
  localparam logic [OP_W-1:0] OP_XOR = 4'b1010;
  localparam logic [OP_W-1:0] OP_LTH = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } issuer_state_t;

endpackage

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - issues one command to the registered ALU and returns its result
import alu_pkg::*;

module alu_cmd_issuer #(
  parameter int ALU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_opcode,
  input  logic [ALU_W-1:0] cmd_a,
  input  logic [ALU_W-1:0] cmd_b,
  input  logic             cmd_use_acc,
  input  logic             cmd_acc_wr,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [OP_W-1:0]  alu_opcode,
  input  logic [ALU_W-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ALU_W-1:0] res_data,
  output logic [ALU_W-1:0] acc,
  output logic [7:0]       op_count
);

  localparam int CNT_W = 3;

  issuer_state_t    state_q;
  issuer_state_t    state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             acc_wr_q;

  // Ready is masked by reset so the source never sees a ready issuer while held in reset.
  assign cmd_ready = rst_n && (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_HOLD);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept, wait out the ALU latency, capture once, hold until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cmd_valid) state_d = ST_WAIT;
      ST_WAIT:    if (cnt_q <= CNT_W'(1)) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_HOLD;
      ST_HOLD:    if (res_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand registers load only on acceptance; result, accumulator and count update only in CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      cnt_q      <= '0;
      acc_wr_q   <= 1'b0;
      res_data   <= '0;
      acc        <= '0;
      op_count   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_a      <= cmd_use_acc ? acc : cmd_a;
            alu_b      <= cmd_b;
            alu_opcode <= cmd_opcode;
            acc_wr_q   <= cmd_acc_wr;
            cnt_q      <= CNT_W'(ALU_LATENCY);
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
        ST_CAPTURE: begin
          res_data <= alu_out;
          if (acc_wr_q) acc <= alu_out;
          op_count <= op_count + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
